// File: rtl/bcd_updown_display.sv
// bcd_updown_display: multi-digit BCD up/down counter driving a multiplexed common-anode 7-seg display
module bcd_updown_display #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int DIGITS      = 4,
    parameter bit WRAP        = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    output logic [6:0]          seven_seg,
    output logic [DIGITS-1:0]   an,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                tick,
    output logic                rollover
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);
    localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] S_MAX = SW'(DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [RW-1:0]       refr_q, refr_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d, stepped;
    logic                roll_q, roll_d, carry;
    logic [3:0]          digit;

    // Free-running prescaler and display scan timing, independent of each other
    always_comb begin
        tick    = presc_q == P_MAX;
        presc_d = tick ? '0 : presc_q + 1'b1;
        refr_d  = refr_q == R_MAX ? '0 : refr_q + 1'b1;
        scan_d  = refr_q != R_MAX ? scan_q : scan_q == S_MAX ? '0 : scan_q + 1'b1;
    end

    // Ripple BCD step; a carry/borrow out of the top digit marks the limit
    always_comb begin
        stepped = cnt_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    carry = cnt_q[4*i +: 4] == 4'd9;
                    stepped[4*i +: 4] = carry ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
                end else begin
                    carry = cnt_q[4*i +: 4] == 4'd0;
                    stepped[4*i +: 4] = carry ? 4'd9 : cnt_q[4*i +: 4] - 4'd1;
                end
            end
        end
        cnt_d  = tick && en && !(carry && !WRAP) ? stepped : cnt_q;
        roll_d = tick && en && carry && WRAP;
    end

    // Select the scanned digit and decode it to active-low segments
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < DIGITS; i++)
            if (scan_q == SW'(i)) digit = cnt_q[4*i +: 4];
        an = ~(DIGITS'(1) << scan_q);
        case (digit)
            4'd0:    seven_seg = 7'b0000001;
            4'd1:    seven_seg = 7'b1001111;
            4'd2:    seven_seg = 7'b0010010;
            4'd3:    seven_seg = 7'b0000110;
            4'd4:    seven_seg = 7'b1001100;
            4'd5:    seven_seg = 7'b0100100;
            4'd6:    seven_seg = 7'b0100000;
            4'd7:    seven_seg = 7'b0001111;
            4'd8:    seven_seg = 7'b0000000;
            4'd9:    seven_seg = 7'b0000100;
            default: seven_seg = 7'b1111111;
        endcase
    end

    // State registers; reset overrides any tick or scan event
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            refr_q  <= '0;
            scan_q  <= '0;
            cnt_q   <= '0;
            roll_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            refr_q  <= refr_d;
            scan_q  <= scan_d;
            cnt_q   <= cnt_d;
            roll_q  <= roll_d;
        end
    end

    assign count_bcd = cnt_q;
    assign rollover  = roll_q;
endmodule
